irtcv_txseq: RTL and testbench

Transmit sequencer for the IR transceiver IP. It accepts a frame of data bytes from fabric logic into a small FIFO. On a start request it programs the transceiver over its control bus (frequency register, control register, first data byte), then holds execute while feeding further data bytes as the IP signals data-ready. It sits between fabric host logic and the transceiver's control-bus, execute and status pins, sharing the clock and asynchronous reset of the transceiver.

---
 rtl/irtcv_txseq_pkg.sv | 40 ++++
 rtl/irtcv_txseq_if.sv | 42 ++++
 rtl/irtcv_txseq_fifo.sv | 61 ++++++
 rtl/irtcv_txseq.sv | 220 ++++++++++++++++++++++
 tb/tb_irtcv_txseq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irtcv_txseq_pkg.sv
// Shared definitions for the IR transceiver transmit sequencer.
// Contents:
//   state_t                       sequencer state encoding (also the debug view)
//   FR_ADR_DEF/CR_ADR_DEF/DR_ADR_DEF  default transceiver register addresses
//   bus_strb_t, STRB_IDLE/STRB_WRITE  control-bus strobe encoding {cs, we, den}
//   exe_level()                   execute level driven in a given state
package irtcv_txseq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_FR,
        WR_CR,
        WR_DR0,
        EXEC,
        WAIT_DRDY,
        WR_DR,
        DRAIN,
        FLUSH
    } state_t;

    localparam logic [3:0] FR_ADR_DEF = 4'hA;
    localparam logic [3:0] CR_ADR_DEF = 4'h8;
    localparam logic [3:0] DR_ADR_DEF = 4'hB;

    typedef struct packed {
        logic cs;
        logic we;
        logic den;
    } bus_strb_t;

    localparam bus_strb_t STRB_IDLE  = '{cs: 1'b0, we: 1'b0, den: 1'b0};
    localparam bus_strb_t STRB_WRITE = '{cs: 1'b1, we: 1'b1, den: 1'b1};

    // Execute is held from the cycle after the first data write until the
    // frame drains; FLUSH deliberately drops it.
    function automatic logic exe_level(input state_t s);
        return (s == EXEC) || (s == WAIT_DRDY) || (s == WR_DR) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/irtcv_txseq_if.sv
// Control-bus, execute and status pins between the sequencer and the IR
// transceiver IP.
// Signals:
//   irtcv_cs/we/den   write strobes (sequencer -> IP)
//   irtcv_adr         register address (sequencer -> IP)
//   irtcv_wdat        register write data (sequencer -> IP)
//   irtcv_exe         execute level (sequencer -> IP)
//   irtcv_learn       learn request, tied low (sequencer -> IP)
//   irtcv_busy/drdy/err  status (IP -> sequencer)
//
// Handshake: a register write is exactly one cycle with cs=we=den=1 and
// adr/wdat valid; the IP takes it unconditionally, there is no ready/stall.
// Outside a write all strobes, adr and wdat are 0. drdy is the IP's request
// for the next data byte and is honoured at most once per WAIT_DRDY visit,
// so a drdy level held high yields one write every second cycle.
interface irtcv_txseq_if #(
    parameter int ADRW = 4,
    parameter int DATW = 8
);
    logic            irtcv_cs;
    logic            irtcv_we;
    logic            irtcv_den;
    logic [ADRW-1:0] irtcv_adr;
    logic [DATW-1:0] irtcv_wdat;
    logic            irtcv_exe;
    logic            irtcv_learn;
    logic            irtcv_busy;
    logic            irtcv_drdy;
    logic            irtcv_err;

    modport master (
        output irtcv_cs, irtcv_we, irtcv_den, irtcv_adr, irtcv_wdat,
        output irtcv_exe, irtcv_learn,
        input  irtcv_busy, irtcv_drdy, irtcv_err
    );

    modport slave (
        input  irtcv_cs, irtcv_we, irtcv_den, irtcv_adr, irtcv_wdat,
        input  irtcv_exe, irtcv_learn,
        output irtcv_busy, irtcv_drdy, irtcv_err
    );
endinterface

// File: rtl/irtcv_txseq_fifo.sv
// Synchronous byte FIFO holding the frame to transmit.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears pointers/count)
//   push, wdat write side; a push while full is dropped
//   pop        read side; a pop while empty is ignored
//   rdat       head of the FIFO (first-word fall-through)
//   full, cnt  status; cnt ranges 0..2**AW
module irtcv_txseq_fifo #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdat,
    input  logic          pop,
    output logic [DW-1:0] rdat,
    output logic          full,
    output logic [AW:0]   cnt
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (cnt != '0);
    assign rdat    = mem[rd_ptr];

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdat;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo the depth naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/irtcv_txseq.sv
// Transmit sequencer for the IR transceiver IP.
// Takes a frame of bytes from fabric logic into a FIFO; on start it writes
// the frequency register, the control register and the first data byte on
// consecutive cycles, then holds execute and writes one further byte to the
// data register for each drdy request until the frame is sent and the IP
// reports not-busy. An IP error flushes the rest of the frame from the FIFO.
//
// Ports:
//   irtcv_clk, irtcv_rst_async  clock, asynchronous active-high reset
//   fifo_we, fifo_wdat          host push into the frame FIFO
//   fifo_full, fifo_cnt         FIFO status
//   start, frame_len            frame request (sampled in IDLE only)
//   freq_val, cr_val            FR / CR values (sampled with start)
//   seq_busy, seq_done, seq_err sequencer status; done/err are 1-cycle pulses
//   seq_state                   current FSM state for observation
//   bus                         control bus / execute / status (master side)
//
// Optional feature: define IRTCV_TXSEQ_TIMEOUT_EN to add a TO_W-bit watchdog
// on WAIT_DRDY and DRAIN that forces FLUSH (and then seq_err) on expiry.
module irtcv_txseq
  import irtcv_txseq_pkg::*;
#(
  parameter int              ADRW    = 4,
  parameter int              DATW    = 8,
  parameter int              FIFO_AW = 3,
  parameter logic [ADRW-1:0] FR_ADR  = ADRW'(FR_ADR_DEF),
  parameter logic [ADRW-1:0] CR_ADR  = ADRW'(CR_ADR_DEF),
  parameter logic [ADRW-1:0] DR_ADR  = ADRW'(DR_ADR_DEF),
  parameter int              TO_W    = 16
) (
  input  logic               irtcv_clk,
  input  logic               irtcv_rst_async,
  input  logic               fifo_we,
  input  logic [DATW-1:0]    fifo_wdat,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_cnt,
  input  logic               start,
  input  logic [FIFO_AW:0]   frame_len,
  input  logic [DATW-1:0]    freq_val,
  input  logic [DATW-1:0]    cr_val,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_err,
  output state_t             seq_state,
  irtcv_txseq_if.master      bus
);
  state_t            state;
  state_t            state_next;
  logic [FIFO_AW:0]  rem;
  logic [DATW-1:0]   freq_q;
  logic [DATW-1:0]   cr_q;
  logic              done_set;
  logic              err_set;
  logic              to_hit;
  logic              pop;
  logic [DATW-1:0]   fifo_rdat;
  bus_strb_t         strb;
  logic [ADRW-1:0]   adr;
  logic [DATW-1:0]   wdat;

  irtcv_txseq_fifo #(
    .AW (FIFO_AW),
    .DW (DATW)
  ) u_fifo (
    .clk  (irtcv_clk),
    .rst  (irtcv_rst_async),
    .push (fifo_we),
    .wdat (fifo_wdat),
    .pop  (pop),
    .rdat (fifo_rdat),
    .full (fifo_full),
    .cnt  (fifo_cnt)
  );

`ifdef IRTCV_TXSEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Restarts on every state change, so it measures time spent in the
  // current waiting state only.
  always_ff @(posedge irtcv_clk or posedge irtcv_rst_async) begin
    if (irtcv_rst_async) begin
      to_cnt <= '0;
    end else if (state_next != state) begin
      to_cnt <= '0;
    end else if (state == WAIT_DRDY || state == DRAIN) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (&to_cnt) && (state == WAIT_DRDY || state == DRAIN);
`else
  assign to_hit = 1'b0;
`endif

  // State register plus the registers that travel with it.
  always_ff @(posedge irtcv_clk or posedge irtcv_rst_async) begin
    if (irtcv_rst_async) begin
      state    <= IDLE;
      rem      <= '0;
      freq_q   <= '0;
      cr_q     <= '0;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      state    <= state_next;
      seq_done <= done_set;
      seq_err  <= err_set;
      if (state == IDLE && start) begin
        rem    <= frame_len;
        freq_q <= freq_val;
        cr_q   <= cr_val;
      end else if (pop) begin
        rem <= rem - 1'b1;
      end
    end
  end

  // Next-state logic. rem counts bytes still to leave the FIFO: in EXEC it
  // already excludes DR0, in WR_DR it still includes the byte being sent.
  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            done_set = 1'b1;
          end else if (frame_len > fifo_cnt) begin
            err_set = 1'b1;
          end else begin
            state_next = WR_FR;
          end
        end
      end
      WR_FR:  state_next = WR_CR;
      WR_CR:  state_next = WR_DR0;
      WR_DR0: state_next = EXEC;
      EXEC: begin
        if (bus.irtcv_err) begin
          state_next = FLUSH;
        end else if (rem != '0) begin
          state_next = WAIT_DRDY;
        end else begin
          state_next = DRAIN;
        end
      end
      WAIT_DRDY: begin
        if (bus.irtcv_err || to_hit) begin
          state_next = FLUSH;
        end else if (bus.irtcv_drdy) begin
          state_next = WR_DR;
        end
      end
      WR_DR: begin
        if (bus.irtcv_err) begin
          state_next = FLUSH;
        end else if (rem > (FIFO_AW + 1)'(1)) begin
          state_next = WAIT_DRDY;
        end else begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.irtcv_err || to_hit) begin
          state_next = FLUSH;
        end else if (!bus.irtcv_busy) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      FLUSH: begin
        // The last byte is popped in the same cycle the exit is taken.
        if (rem <= (FIFO_AW + 1)'(1)) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    strb = STRB_IDLE;
    adr  = '0;
    wdat = '0;
    pop  = 1'b0;
    case (state)
      WR_FR: begin
        strb = STRB_WRITE;
        adr  = FR_ADR;
        wdat = freq_q;
      end
      WR_CR: begin
        strb = STRB_WRITE;
        adr  = CR_ADR;
        wdat = cr_q;
      end
      WR_DR0, WR_DR: begin
        strb = STRB_WRITE;
        adr  = DR_ADR;
        wdat = fifo_rdat;
        pop  = 1'b1;
      end
      FLUSH: pop = (rem != '0);
      default: ;
    endcase
  end

  assign bus.irtcv_cs    = strb.cs;
  assign bus.irtcv_we    = strb.we;
  assign bus.irtcv_den   = strb.den;
  assign bus.irtcv_adr   = adr;
  assign bus.irtcv_wdat  = wdat;
  assign bus.irtcv_exe   = exe_level(state);
  assign bus.irtcv_learn = 1'b0;
  assign seq_busy        = (state != IDLE);
  assign seq_state       = state;
endmodule

// File: tb/tb_irtcv_txseq.sv
// Testbench for irtcv_txseq: vector table of frames plus hand-written
// sequences for exact timing, error flush, reset and (optionally) timeout.
module tb_irtcv_txseq;
  import irtcv_txseq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       fifo_we = 1'b0;
  logic [7:0] fifo_wdat = '0;
  logic       fifo_full;
  logic [3:0] fifo_cnt;
  logic       start = 1'b0;
  logic [3:0] frame_len = '0;
  logic [7:0] freq_val = '0;
  logic [7:0] cr_val = '0;
  logic       seq_busy, seq_done, seq_err;
  state_t     seq_state;

  irtcv_txseq_if #(.ADRW(4), .DATW(8)) bus_if ();

  irtcv_txseq #(.TO_W(4)) dut (
    .irtcv_clk       (clk),
    .irtcv_rst_async (rst),
    .fifo_we         (fifo_we),
    .fifo_wdat       (fifo_wdat),
    .fifo_full       (fifo_full),
    .fifo_cnt        (fifo_cnt),
    .start           (start),
    .frame_len       (frame_len),
    .freq_val        (freq_val),
    .cr_val          (cr_val),
    .seq_busy        (seq_busy),
    .seq_done        (seq_done),
    .seq_err         (seq_err),
    .seq_state       (seq_state),
    .bus             (bus_if)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q[$];   // expected bus writes {adr, wdat}
  logic [7:0]  mq[$];      // reference contents of the FIFO
  logic [11:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every bus write must match the head of exp_q; idle bus must be all 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.irtcv_cs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL bus_unexpected: got write %0h<-%0h, expected none",
                   bus_if.irtcv_adr, bus_if.irtcv_wdat);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("bus_write", {bus_if.irtcv_we, bus_if.irtcv_den, bus_if.irtcv_adr,
              bus_if.irtcv_wdat}, {2'b11, mon_exp});
        end
      end else begin
        chk("bus_idle", {bus_if.irtcv_we, bus_if.irtcv_den, bus_if.irtcv_adr,
            bus_if.irtcv_wdat}, 32'h0);
      end
      chk("learn_low", bus_if.irtcv_learn, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    fifo_we   = 1'b1;
    fifo_wdat = b;
    @(negedge clk);
    fifo_we   = 1'b0;
    if (mq.size() < 8) mq.push_back(b);
  endtask

  task automatic expect_header(input logic [7:0] f, input logic [7:0] c);
    exp_q.push_back({4'hA, f});
    exp_q.push_back({4'h8, c});
  endtask

  task automatic pulse_start(input logic [3:0] len, input logic [7:0] f, input logic [7:0] c);
    start     = 1'b1;
    frame_len = len;
    freq_val  = f;
    cr_val    = c;
    @(negedge clk);
    start     = 1'b0;
  endtask

  typedef struct {
    int         npush;
    logic [3:0] len;
    logic [7:0] freq;
    logic [7:0] cr;
    int         pre_cnt;
    bit         ok;
    int         post_cnt;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    bit seen;
    bit got_done;
    bit got_err;
    seen = 0; got_done = 0; got_err = 0;
    for (int i = 0; i < v.npush; i++) push_byte(8'($urandom_range(0, 255)));
    chk($sformatf("v%0d_pre_cnt", idx), fifo_cnt, v.pre_cnt);
    chk($sformatf("v%0d_pre_full", idx), fifo_full, (v.pre_cnt == 8));
    if (v.ok && v.len != 0) begin
      expect_header(v.freq, v.cr);
      for (int i = 0; i < int'(v.len); i++) exp_q.push_back({4'hB, mq.pop_front()});
    end
    pulse_start(v.len, v.freq, v.cr);
    for (int c = 0; c < 300; c++) begin
      if (seq_done || seq_err) begin
        seen = 1; got_done = seq_done; got_err = seq_err;
        break;
      end
      bus_if.irtcv_drdy = 1'($urandom_range(0, 1));
      bus_if.irtcv_busy = (exp_q.size() != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus_if.irtcv_drdy = 1'b0;
    bus_if.irtcv_busy = 1'b1;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL v%0d_timeout: got no done/err, expected one within 300 cycles", idx);
    end else begin
      chk($sformatf("v%0d_done", idx), got_done, v.ok);
      chk($sformatf("v%0d_err", idx), got_err, !v.ok);
    end
    chk($sformatf("v%0d_writes_left", idx), exp_q.size(), 0);
    chk($sformatf("v%0d_post_cnt", idx), fifo_cnt, v.post_cnt);
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), seq_busy, 0);
    chk($sformatf("v%0d_pulse_end", idx), {seq_done, seq_err}, 0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[11];
  bit   seen;
  bit   prev_exe;
  int   wait_cycles;

  initial begin
    //            npush len   freq   cr     pre ok  post
    vecs[0]  = '{3, 4'd3, 8'h5A, 8'h81, 3, 1'b1, 0};
    vecs[1]  = '{2, 4'd4, 8'h10, 8'h20, 2, 1'b0, 2};  // too few bytes
    vecs[2]  = '{1, 4'd3, 8'h33, 8'h44, 3, 1'b1, 0};
    vecs[3]  = '{0, 4'd0, 8'h55, 8'h66, 0, 1'b1, 0};  // empty frame
    vecs[4]  = '{9, 4'd8, 8'hC3, 8'h3C, 8, 1'b1, 0};  // 9th push dropped
    vecs[5]  = '{5, 4'd2, 8'h01, 8'h02, 5, 1'b1, 3};
    vecs[6]  = '{0, 4'd3, 8'hFE, 8'hEF, 3, 1'b1, 0};
    vecs[7]  = '{1, 4'd2, 8'h77, 8'h88, 1, 1'b0, 1};
    vecs[8]  = '{1, 4'd2, 8'h99, 8'hAA, 2, 1'b1, 0};
    vecs[9]  = '{6, 4'd6, 8'hBB, 8'hCC, 6, 1'b1, 0};
    vecs[10] = '{0, 4'd1, 8'hDD, 8'hEE, 0, 1'b0, 0};  // 1 > 0 queued

    bus_if.irtcv_busy = 1'b1;
    bus_if.irtcv_drdy = 1'b0;
    bus_if.irtcv_err  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", seq_busy, 0);
    chk("rst_pulses", {seq_done, seq_err}, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_strobes", {bus_if.irtcv_cs, bus_if.irtcv_we, bus_if.irtcv_den}, 0);
    chk("rst_exe", bus_if.irtcv_exe, 0);
    chk("rst_state", seq_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Exact timing of the reference frame.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    expect_header(8'h5A, 8'h81);
    for (int i = 0; i < 3; i++) exp_q.push_back({4'hB, mq.pop_front()});
    pulse_start(4'd3, 8'h5A, 8'h81);
    chk("a_fr_cs", bus_if.irtcv_cs, 1);
    chk("a_fr_state", seq_state, WR_FR);
    chk("a_fr_busy", seq_busy, 1);
    @(negedge clk); chk("a_cr_cs", bus_if.irtcv_cs, 1);
    @(negedge clk); chk("a_dr0_cs", bus_if.irtcv_cs, 1);
    chk("a_dr0_exe", bus_if.irtcv_exe, 0);
    @(negedge clk); chk("a_exec_exe", bus_if.irtcv_exe, 1);
    chk("a_exec_cs", bus_if.irtcv_cs, 0);
    @(negedge clk); chk("a_wait_state", seq_state, WAIT_DRDY);
    chk("a_wait_exe", bus_if.irtcv_exe, 1);
    bus_if.irtcv_drdy = 1'b1;   // held high: one write per two cycles
    @(negedge clk); chk("a_dr1_cs", bus_if.irtcv_cs, 1);
    @(negedge clk); chk("a_gap_cs", bus_if.irtcv_cs, 0);
    @(negedge clk); chk("a_dr2_cs", bus_if.irtcv_cs, 1);
    bus_if.irtcv_drdy = 1'b0;
    @(negedge clk); chk("a_drain_state", seq_state, DRAIN);
    chk("a_drain_exe", bus_if.irtcv_exe, 1);
    chk("a_drain_done", seq_done, 0);
    bus_if.irtcv_busy = 1'b0;
    @(negedge clk); chk("a_done", seq_done, 1);
    chk("a_done_busy", seq_busy, 0);
    chk("a_done_exe", bus_if.irtcv_exe, 0);
    chk("a_done_cnt", fifo_cnt, 0);
    chk("a_writes_left", exp_q.size(), 0);
    bus_if.irtcv_busy = 1'b1;
    @(negedge clk); chk("a_done_pulse", seq_done, 0);

    // Error in WAIT_DRDY with 2 bytes remaining; a 4th byte is beyond the frame.
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    expect_header(8'h12, 8'h34);
    exp_q.push_back({4'hB, mq.pop_front()});
    pulse_start(4'd3, 8'h12, 8'h34);
    repeat (4) @(negedge clk);
    chk("b_wait_state", seq_state, WAIT_DRDY);
    bus_if.irtcv_err  = 1'b1;
    bus_if.irtcv_drdy = 1'b1;   // err wins over drdy
    @(negedge clk);
    bus_if.irtcv_err  = 1'b0;
    bus_if.irtcv_drdy = 1'b0;
    chk("b_flush_state", seq_state, FLUSH);
    chk("b_flush_exe", bus_if.irtcv_exe, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (seq_err) begin seen = 1; break; end
      chk("b_no_done", seq_done, 0);
      @(negedge clk);
    end
    chk("b_err_seen", seen, 1);
    chk("b_left_cnt", fifo_cnt, 1);
    void'(mq.pop_front());
    void'(mq.pop_front());
    run_vec(20, '{0, 4'd1, 8'h56, 8'h78, 1, 1'b1, 0});  // the 4th byte is next

    // Reset while waiting for drdy.
    push_byte(8'hA5); push_byte(8'h5A);
    expect_header(8'h9A, 8'hBC);
    exp_q.push_back({4'hB, mq.pop_front()});
    pulse_start(4'd2, 8'h9A, 8'hBC);
    repeat (4) @(negedge clk);
    chk("c_wait_exe", bus_if.irtcv_exe, 1);
    #2 rst = 1'b1;
    #1;
    chk("c_rst_exe", bus_if.irtcv_exe, 0);
    chk("c_rst_cs", bus_if.irtcv_cs, 0);
    chk("c_rst_busy", seq_busy, 0);
    chk("c_rst_cnt", fifo_cnt, 0);
    chk("c_rst_state", seq_state, IDLE);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("c_writes_left", exp_q.size(), 0);
    @(negedge clk);
    run_vec(21, '{2, 4'd2, 8'h42, 8'h24, 2, 1'b1, 0});

`ifdef IRTCV_TXSEQ_TIMEOUT_EN
    // drdy never comes: the watchdog expires after 16 cycles in WAIT_DRDY.
    push_byte(8'h01); push_byte(8'h02);
    expect_header(8'h0F, 8'hF0);
    exp_q.push_back({4'hB, mq.pop_front()});
    pulse_start(4'd2, 8'h0F, 8'hF0);
    seen = 0; prev_exe = 1'b1; wait_cycles = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (seq_err) begin seen = 1; break; end
      if (seq_state == WAIT_DRDY) wait_cycles++;
      prev_exe = bus_if.irtcv_exe;
    end
    chk("t_err_seen", seen, 1);
    chk("t_wait_cycles", wait_cycles, 16);
    chk("t_exe_dropped", prev_exe, 0);
    chk("t_cnt", fifo_cnt, 0);
    void'(mq.pop_front());
    @(negedge clk);
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
